level_select_ctrl: RTL and testbench

- Player-facing input side of the level interface. It converts two raw push-buttons (up/down) into the 4-bit level code consumed by the LED level-display/blink block.
- Each button is synchronised and debounced. The level steps once per clean press and saturates at 1..8.
- Optional hold-to-repeat stepping.
- Sits between board buttons and the display and game logic.

---
 rtl/level_pkg.sv | 17 +
 rtl/button_debounce.sv | 59 +++++
 rtl/level_select_ctrl.sv | 154 +++++++++++++++
 tb/tb_level_select_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// Shared level-interface types: level code width, default range, repeat-FSM states.
// Also used by the LED level-display/blink block.
package level_pkg;

    localparam int unsigned LEVEL_W       = 4;
    localparam int unsigned LEVEL_MIN_DEF = 1;
    localparam int unsigned LEVEL_MAX_DEF = 8;

    typedef logic [LEVEL_W-1:0] level_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HELD,
        RPT_REPEAT
    } rpt_state_e;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, stable-count debouncer and one-cycle press pulse for one button.
// The press pulse is registered from the debounced edge so it lags the debounced value by one cycle.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_i,
    output logic btn_db_o,
    output logic press_o
);

    localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic             db_prev_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter only runs while the synced value disagrees; it stops at CNT_LAST, never wraps.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_raw_i;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            press_q   <= db_q & ~db_prev_q;
            cnt_q     <= cnt_d;
        end
    end

    assign btn_db_o = db_q;
    assign press_o  = press_q;

endmodule

// File: rtl/level_select_ctrl.sv
// Up/down push-buttons to saturating level code with change pulse.
// Optional hold-to-repeat stepping when AUTO_REPEAT_EN is defined.
module level_select_ctrl
    import level_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LEVEL_MIN       = LEVEL_MIN_DEF,
    parameter int unsigned LEVEL_MAX       = LEVEL_MAX_DEF,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   btn_up_raw,
    input  logic   btn_down_raw,
    input  logic   level_lock,
    output level_t level,
    output logic   level_changed,
    output logic   btn_up_db,
    output logic   btn_down_db
);

    localparam level_t LMIN = level_t'(LEVEL_MIN);
    localparam level_t LMAX = level_t'(LEVEL_MAX);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LEVEL_MAX > 15 || LEVEL_MAX <= LEVEL_MIN) begin : g_bad_range
        $error("LEVEL_MAX must be <= 15 and > LEVEL_MIN");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
    end

    logic [1:0] press;   // [0] up, [1] down
    logic [1:0] db;
    logic [1:0] step;
    level_t     level_q;
    level_t     level_d;
    logic       changed_q;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk      (clk),
        .reset    (reset),
        .btn_raw_i(btn_up_raw),
        .btn_db_o (db[0]),
        .press_o  (press[0])
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk      (clk),
        .reset    (reset),
        .btn_raw_i(btn_down_raw),
        .btn_db_o (db[1]),
        .press_o  (press[1])
    );

`ifdef AUTO_REPEAT_EN
    localparam int unsigned       RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned       RCNT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RCNT_W-1:0] RD_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RP_LAST  = RCNT_W'(REPEAT_PERIOD - 1);

    rpt_state_e              st_q  [2];
    rpt_state_e              st_d  [2];
    logic [1:0][RCNT_W-1:0]  rcnt_q;
    logic [1:0][RCNT_W-1:0]  rcnt_d;
    logic [1:0]              rpt_step;

    // A press swallowed by the lock never arms the FSM, so releasing the lock mid-hold stays silent.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            st_d[i]     = st_q[i];
            rcnt_d[i]   = rcnt_q[i];
            rpt_step[i] = 1'b0;
            case (st_q[i])
                RPT_IDLE: begin
                    rcnt_d[i] = '0;
                    if (press[i] && !level_lock) st_d[i] = RPT_HELD;
                end
                RPT_HELD: begin
                    if (!db[i]) begin
                        st_d[i]   = RPT_IDLE;
                        rcnt_d[i] = '0;
                    end else if (rcnt_q[i] == RD_LAST) begin
                        st_d[i]     = RPT_REPEAT;
                        rcnt_d[i]   = '0;
                        rpt_step[i] = 1'b1;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (!db[i]) begin
                        st_d[i]   = RPT_IDLE;
                        rcnt_d[i] = '0;
                    end else if (rcnt_q[i] == RP_LAST) begin
                        rcnt_d[i]   = '0;
                        rpt_step[i] = 1'b1;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    st_d[i]   = RPT_IDLE;
                    rcnt_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) st_q[i] <= RPT_IDLE;
            rcnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) st_q[i] <= st_d[i];
            rcnt_q <= rcnt_d;
        end
    end

    assign step = press | rpt_step;
`else
    assign step = press;
`endif

    always_comb begin
        level_d = level_q;
        if (!level_lock) begin
            if (step[0] && !step[1] && level_q < LMAX) begin
                level_d = level_q + 1'b1;
            end else if (step[1] && !step[0] && level_q > LMIN) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q   <= LMIN;
            changed_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            changed_q <= (level_d != level_q);
        end
    end

    assign level         = level_q;
    assign level_changed = changed_q;
    assign btn_up_db     = db[0];
    assign btn_down_db   = db[1];

endmodule

// File: tb/tb_level_select_ctrl.sv
// Scoreboard bench for level_select_ctrl: stimulus queues expected (level, cycle) pairs,
// a monitor pops one on every level_changed pulse.
module tb_level_select_ctrl;
    import level_pkg::*;

    localparam int unsigned DC = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 5;
    localparam int unsigned LAT = 8;   // drive on negedge -> sampling edge +1 -> level 7 edges later

    logic   clk = 1'b0;
    logic   reset;
    logic   up;
    logic   dn;
    logic   lock;
    level_t level;
    logic   changed;
    logic   up_db;
    logic   dn_db;

    always #5 clk = ~clk;

    level_select_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .LEVEL_MIN      (1),
        .LEVEL_MAX      (8),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up_raw   (up),
        .btn_down_raw (dn),
        .level_lock   (lock),
        .level        (level),
        .level_changed(changed),
        .btn_up_db    (up_db),
        .btn_down_db  (dn_db)
    );

    typedef struct {
        int unsigned lvl;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && changed) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_change: actual level=%0d required no change (cycle %0d)", level, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("level_value", int'(level), e.lvl);
                check("level_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_lvl(input int unsigned lvl, input int unsigned delay);
        exp_t e;
        e.lvl = lvl;
        e.cyc = cyc + delay;
        sb.push_back(e);
    endtask

    // Press and release one button; exp_lvl = 0 means no level change expected.
    task automatic press(input bit is_up, input int unsigned exp_lvl);
        if (exp_lvl != 0) expect_lvl(exp_lvl, LAT);
        if (is_up) up = 1'b1; else dn = 1'b1;
        wait_neg(12);
        if (is_up) up = 1'b0; else dn = 1'b0;
        wait_neg(12);
    endtask

    initial begin
        reset = 1'b1;
        up    = 1'b0;
        dn    = 1'b0;
        lock  = 1'b0;
        #1;
        check("reset_level", int'(level), 1);
        check("reset_changed", int'(changed), 0);
        check("reset_up_db", int'(up_db), 0);
        check("reset_dn_db", int'(dn_db), 0);
        wait_neg(2);
        reset = 1'b0;
        wait_neg(2);

        // clean press with latency and debounced-state checks
        expect_lvl(2, LAT);
        up = 1'b1;
        wait_neg(9);
        check("up_db_held", int'(up_db), 1);
        up = 1'b0;
        wait_neg(9);
        check("up_db_released", int'(up_db), 0);

        // bouncy press: runs of two are shorter than the debounce window
        up = 1'b1; wait_neg(2);
        up = 1'b0; wait_neg(2);
        up = 1'b1; wait_neg(2);
        up = 1'b0; wait_neg(2);
        press(1'b1, 3);
        check("after_bounce", int'(level), 3);

        for (int unsigned l = 4; l <= 8; l++) press(1'b1, l);
        press(1'b1, 0);
        check("sat_max", int'(level), 8);

        for (int unsigned l = 7; l >= 1; l--) press(1'b0, l);
        press(1'b0, 0);
        check("sat_min", int'(level), 1);

        // simultaneous press
        up = 1'b1;
        dn = 1'b1;
        wait_neg(12);
        up = 1'b0;
        dn = 1'b0;
        wait_neg(12);
        check("simultaneous", int'(level), 1);

        // lock during press, released while still held
        lock = 1'b1;
        up   = 1'b1;
        wait_neg(12);
        lock = 1'b0;
        wait_neg(8);
        up = 1'b0;
        wait_neg(12);
        check("lock_release_held", int'(level), 1);
        press(1'b1, 2);

        // async reset while a button is held
        expect_lvl(3, LAT);
        up = 1'b1;
        wait_neg(10);
        check("pre_reset_level", int'(level), 3);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_level", int'(level), 1);
        check("midrun_reset_changed", int'(changed), 0);
        check("midrun_reset_up_db", int'(up_db), 0);
        @(negedge clk);
        reset = 1'b0;
        expect_lvl(2, LAT);
        wait_neg(12);
        up = 1'b0;
        wait_neg(12);
        check("post_reset_level", int'(level), 2);

`ifdef AUTO_REPEAT_EN
        press(1'b0, 1);
        expect_lvl(2, LAT);
        expect_lvl(3, LAT + RD);
        for (int unsigned l = 4; l <= 8; l++) expect_lvl(l, LAT + RD + (l - 3) * RP);
        up = 1'b1;
        wait_neg(70);
        up = 1'b0;
        wait_neg(30);
        check("repeat_final", int'(level), 8);
`else
        wait_neg(10);
        check("final_level", int'(level), 2);
`endif

        wait_neg(10);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
